// File: rtl/cache_pkg.sv
// Shared constants and types for the direct-mapped cache storage core.
package cache_pkg;

  localparam int DATA_W          = 32;
  localparam int INDEX_W         = 5;
  localparam int TAG_W           = 6;
  localparam int WORDS_PER_BLOCK = 8;

  localparam int OFFSET_W = $clog2(WORDS_PER_BLOCK);
  localparam int LINES    = 1 << INDEX_W;

  typedef logic [TAG_W-1:0]    tag_t;
  typedef logic [INDEX_W-1:0]  index_t;
  typedef logic [OFFSET_W-1:0] offset_t;
  typedef logic [DATA_W-1:0]   word_t;

endpackage

// File: rtl/cache_tag_ram.sv
// Per-line tag and valid storage with asynchronous clear and combinational read.
// Optional hit output when CACHE_HIT_EN is defined.
module cache_tag_ram #(
  parameter int INDEX_W = cache_pkg::INDEX_W,
  parameter int TAG_W   = cache_pkg::TAG_W,
  localparam int LINES  = 1 << INDEX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] index,
  input  logic               we_tag,
  input  logic [TAG_W-1:0]   tag_in,
  output logic [TAG_W-1:0]   tag_out,
  output logic               valid_out
`ifdef CACHE_HIT_EN
  , output logic             hit
`endif
);

  logic [TAG_W-1:0] tag_reg [LINES];
  logic [LINES-1:0] valid_reg;

  // Tags are cleared along with valid so tag_out reads 0 after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_reg[i] <= '0;
      end
    end else if (we_tag) begin
      tag_reg[index]   <= tag_in;
      valid_reg[index] <= 1'b1;
    end
  end

  assign tag_out   = tag_reg[index];
  assign valid_out = valid_reg[index];

`ifdef CACHE_HIT_EN
  assign hit = valid_reg[index] && (tag_reg[index] == tag_in);
`endif

endmodule

// File: rtl/cache_array.sv
// Direct-mapped cache storage core: tag/valid RAM plus banked data RAM, async reads.
// Define CACHE_HIT_EN to add a combinational hit output.
module cache_array #(
  parameter int DATA_W          = cache_pkg::DATA_W,
  parameter int INDEX_W         = cache_pkg::INDEX_W,
  parameter int TAG_W           = cache_pkg::TAG_W,
  parameter int WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK,
  localparam int OFFSET_W       = $clog2(WORDS_PER_BLOCK),
  localparam int LINES          = 1 << INDEX_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [INDEX_W-1:0]  index,
  input  logic [OFFSET_W-1:0] word_sel,
  input  logic                we_data,
  input  logic                we_tag,
  input  logic [TAG_W-1:0]    tag_in,
  input  logic [DATA_W-1:0]   data_in,
  output logic [TAG_W-1:0]    tag_out,
  output logic                valid_out,
  output logic [DATA_W-1:0]   data_out
`ifdef CACHE_HIT_EN
  , output logic              hit
`endif
);

  cache_tag_ram #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_tag_ram (
    .clk       (clk),
    .rst       (rst),
    .index     (index),
    .we_tag    (we_tag),
    .tag_in    (tag_in),
    .tag_out   (tag_out),
    .valid_out (valid_out)
`ifdef CACHE_HIT_EN
    , .hit     (hit)
`endif
  );

  // One bank per word position; each bank is an unreset RAM indexed by line.
  logic [DATA_W-1:0] bank_rd [WORDS_PER_BLOCK];

  generate
    for (genvar gi = 0; gi < WORDS_PER_BLOCK; gi++) begin : g_bank
      logic [DATA_W-1:0] mem [LINES];

      // rst is sampled only to block writes while reset is held.
      always_ff @(posedge clk) begin
        if (rst && we_data && (word_sel == OFFSET_W'(gi))) begin
          mem[index] <= data_in;
        end
      end

      assign bank_rd[gi] = mem[index];
    end
  endgenerate

  assign data_out = bank_rd[word_sel];

endmodule

// File: tb/tb_cache_array.sv
// Randomized self-checking bench for cache_array against an array-based reference model.
module tb_cache_array;
  import cache_pkg::*;

  logic    clk = 1'b0;
  logic    rst;
  index_t  index;
  offset_t word_sel;
  logic    we_data, we_tag;
  tag_t    tag_in;
  word_t   data_in;
  tag_t    tag_out;
  logic    valid_out;
  word_t   data_out;
`ifdef CACHE_HIT_EN
  logic    hit;
`endif

  int tests = 0;
  int fails = 0;

  // Reference model: plain arrays of what each line/word must hold.
  tag_t  m_tag   [LINES];
  bit    m_valid [LINES];
  word_t m_data  [LINES][WORDS_PER_BLOCK];
  bit    m_known [LINES][WORDS_PER_BLOCK];

  cache_array dut (
    .clk       (clk),
    .rst       (rst),
    .index     (index),
    .word_sel  (word_sel),
    .we_data   (we_data),
    .we_tag    (we_tag),
    .tag_in    (tag_in),
    .data_in   (data_in),
    .tag_out   (tag_out),
    .valid_out (valid_out),
    .data_out  (data_out)
`ifdef CACHE_HIT_EN
    , .hit     (hit)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) begin
      m_tag[i]   = '0;
      m_valid[i] = 1'b0;
    end
  endtask

  always @(negedge rst) model_clear();

  always @(posedge clk) begin
    if (rst === 1'b1) begin
      if (we_tag) begin
        m_tag[index]   = tag_in;
        m_valid[index] = 1'b1;
      end
      if (we_data) begin
        m_data[index][word_sel]  = data_in;
        m_known[index][word_sel] = 1'b1;
      end
    end
  end

  // Mid-cycle compare: write-cycle reads must still show pre-edge contents.
  always @(negedge clk) begin
    chk("cmp_tag", 64'(tag_out), 64'(m_tag[index]));
    chk("cmp_valid", 64'(valid_out), 64'(m_valid[index]));
    if (m_known[index][word_sel])
      chk("cmp_data", 64'(data_out), 64'(m_data[index][word_sel]));
`ifdef CACHE_HIT_EN
    chk("cmp_hit", 64'(hit), 64'(m_valid[index] && (m_tag[index] == tag_in)));
`endif
  end

  initial begin
    for (int i = 0; i < LINES; i++)
      for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
        m_known[i][w] = 1'b0;
        m_data[i][w]  = '0;
      end
    model_clear();
    index = '0; word_sel = '0; we_data = 0; we_tag = 0; tag_in = '0; data_in = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #11 rst = 1'b1;

    // Post-reset sweep
    for (int i = 0; i < LINES; i++) begin
      @(posedge clk); #1;
      index = index_t'(i);
      #1;
      chk("sweep_valid", 64'(valid_out), 64'd0);
      chk("sweep_tag", 64'(tag_out), 64'd0);
    end

    // Tag + data write together
    @(posedge clk); #1;
    index = 5'd3; word_sel = 3'd2; tag_in = 6'b101010; data_in = 32'hDEADBEEF;
    we_tag = 1; we_data = 1;
    #1 chk("old_valid_during_write", 64'(valid_out), 64'd0);
    chk("old_tag_during_write", 64'(tag_out), 64'd0);
    @(posedge clk); #1;
    we_tag = 0; we_data = 0;
    #1 chk("wr_tag", 64'(tag_out), 64'h2A);
    chk("wr_valid", 64'(valid_out), 64'd1);
    chk("wr_data", 64'(data_out), 64'hDEADBEEF);

    // Data-only write, other word intact, tag untouched
    @(posedge clk); #1;
    word_sel = 3'd5; data_in = 32'hCAFEBABE; tag_in = 6'b000111; we_data = 1;
    @(posedge clk); #1;
    we_data = 0;
    #1 chk("wd_word5", 64'(data_out), 64'hCAFEBABE);
    word_sel = 3'd2;
    #1 chk("wd_word2", 64'(data_out), 64'hDEADBEEF);
    chk("wd_tag_kept", 64'(tag_out), 64'h2A);
    chk("wd_valid_kept", 64'(valid_out), 64'd1);

    // Tag-only write at index 10
    @(posedge clk); #1;
    index = 5'd10; tag_in = 6'b111100; we_tag = 1;
    @(posedge clk); #1;
    we_tag = 0;
    #1 chk("wt_valid10", 64'(valid_out), 64'd1);
    chk("wt_tag10", 64'(tag_out), 64'h3C);
    index = 5'd3;
    #1 chk("wt_tag3", 64'(tag_out), 64'h2A);
    index = 5'd11;
    #1 chk("wt_valid11", 64'(valid_out), 64'd0);

`ifdef CACHE_HIT_EN
    index = 5'd3; tag_in = 6'b101010;
    #1 chk("hit_match", 64'(hit), 64'd1);
    tag_in = 6'b000001;
    #1 chk("hit_tagdiff", 64'(hit), 64'd0);
    index = 5'd7; tag_in = 6'b000000;
    #1 chk("hit_unwritten", 64'(hit), 64'd0);
`endif

    // Asynchronous reset mid-cycle while a tag write is pending
    @(posedge clk); #1;
    index = 5'd5; tag_in = 6'b010101; we_tag = 1;
    #2 rst = 1'b0;
    #1 index = 5'd3;
    #1 chk("arst_valid3", 64'(valid_out), 64'd0);
    chk("arst_tag3", 64'(tag_out), 64'd0);
    index = 5'd10;
    #1 chk("arst_valid10", 64'(valid_out), 64'd0);
    index = 5'd5;
    @(posedge clk); #2;
    we_tag = 0;
    rst = 1'b1;
    #1 chk("arst_nowrite5", 64'(valid_out), 64'd0);
    chk("arst_notag5", 64'(tag_out), 64'd0);

    // Randomized traffic, with occasional mid-cycle resets
    for (int n = 0; n < 600; n++) begin
      @(posedge clk); #1;
      index    = index_t'($urandom_range(0, LINES - 1));
      word_sel = offset_t'($urandom_range(0, WORDS_PER_BLOCK - 1));
      tag_in   = tag_t'($urandom);
      data_in  = word_t'($urandom);
      we_tag   = ($urandom_range(0, 3) == 0);
      we_data  = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 79) == 0) begin
        #2 rst = 1'b0;
        #4 rst = 1'b1;
      end
    end
    @(posedge clk); #1;
    we_tag = 0; we_data = 0;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cache_array.md
Name: cache_array

Overview:
Storage core of a direct-mapped cache: per-line tag RAM, valid bits and data RAM of WORDS_PER_BLOCK words per line. It holds no replacement or miss policy. The cache controller drives index/word_sel/tag and the write strobes, then compares tag_out/valid_out against the request itself.

Parameters:
DATA_W, 32, width of one data word
INDEX_W, 5, line index width; LINES = 2**INDEX_W (32)
TAG_W, 6, stored tag width
WORDS_PER_BLOCK, 8, words per line; must be a power of two ≥2; OFFSET_W = log2(WORDS_PER_BLOCK) (3)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active-low (asserted when 0)
index  in  INDEX_W  line select for read and write
word_sel  in  OFFSET_W  word-within-line select for data read/write
we_data  in  1  write data_in to data[index][word_sel] at the clock edge
we_tag  in  1  write tag_in to tag[index] and set valid[index] at the clock edge
tag_in  in  TAG_W  tag to store
data_in  in  DATA_W  word to store
tag_out  out  TAG_W  tag[index], combinational
valid_out  out  1  valid[index], combinational
data_out  out  DATA_W  data[index][word_sel], combinational

Behaviour:
- Reset (rst=0, asynchronous): all LINES valid bits cleared to 0, all tags cleared to 0. The data RAM is not reset (RAM-inferable).
- Reset while writing: reset wins; no write occurs while rst=0.
- After reset: valid_out=0 and tag_out=0 for every index. data_out is unspecified until the word is written.
- Writes are synchronous on the rising clk edge with rst=1:
  - we_tag: tag[index]<=tag_in, valid[index]<=1.
  - we_data: data[index][word_sel]<=data_in.
  - we_tag and we_data together: both update in the same edge.
  - we_data never alters tag or valid. we_tag never alters data.
- Reads are asynchronous: outputs follow index/word_sel combinationally, with zero latency.
- Read timing around a write: during the write cycle, outputs show the old contents; the new contents are visible immediately after the edge.
- No bypass from data_in to data_out.
- Valid bits are only ever set by we_tag and only cleared by reset; there is no per-line invalidate.
- Outputs are raw: tag_out and data_out are driven even when valid_out=0.
- Index and word_sel cover the full address space, so no out-of-range case exists.

Optional Feature:
Macro CACHE_HIT_EN.
- Defined: adds output port hit (1 bit, combinational) = valid[index] && (tag[index]==tag_in).
- Not defined: no hit port; comparison is left to the controller.
- All other behaviour is identical in both builds.

Decomposition:
- Package cache_pkg holds:
  - default constants DATA_W, INDEX_W, TAG_W, WORDS_PER_BLOCK;
  - derived OFFSET_W and LINES;
  - typedefs tag_t, index_t, offset_t, word_t.
- One sub-module, cache_tag_ram: tag and valid arrays with async-active-low clear, write on we_tag, and combinational read. It also produces hit when CACHE_HIT_EN is defined.
- The data RAM stays inline in cache_array.

Test Plan:
- Reset with rst=0, release at 12 ns, then sweep index 0..31 -> valid_out=0 and tag_out=0 everywhere.
- index=3, word_sel=2, tag_in=6'b101010, data_in=32'hDEADBEEF, we_tag=we_data=1 for one edge, then deassert -> tag_out=6'b101010, valid_out=1, data_out=32'hDEADBEEF. Outputs during the write cycle still show old contents.
- index=3, word_sel=5, data_in=32'hCAFEBABE, we_data=1 only:
  - word_sel=5 -> data_out=32'hCAFEBABE;
  - word_sel=2 -> data_out=32'hDEADBEEF;
  - tag_out stays 6'b101010, valid_out=1.
- index=10, tag_in=6'b111100, we_tag=1 only -> at index 10: valid_out=1, tag_out=6'b111100. Index 3 is unchanged. Index 11 stays valid_out=0.
- Assert rst=0 mid-cycle with we_tag=1 at index 5 -> all valid bits clear immediately without waiting for a clock edge, and no write is committed.
- CACHE_HIT_EN defined:
  - index=3, tag_in=6'b101010 -> hit=1;
  - tag_in=6'b000001 -> hit=0;
  - never-written index 7 -> hit=0.
